// File: rtl/decode_dense_pipe.sv
// decode_dense_pipe: elastic valid/ready pipeline carrying the decode-to-dense
// control and data bundle. `depth` register stages with bubble collapsing,
// synchronous flush, occupancy reporting and asynchronous active-low reset.
// Optional build macro DECODE_DENSE_PIPE_STATS_EN enables the saturating
// stall/transfer statistics counters. Without it, both counter ports read 0.
module decode_dense_pipe #(
    parameter int size            = 3,
    parameter int data_size       = 16,
    parameter int act_type_size   = 4,
    parameter int dense_type_size = 4,
    parameter int cost_type_size  = 8,
    parameter int index_size      = 32,
    parameter int depth           = 2,
    localparam int occ_w          = $clog2(depth + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [act_type_size-1:0]      act_type,
    input  logic [dense_type_size-1:0]    dense_type,
    input  logic [cost_type_size-1:0]     cost_type,
    input  logic [data_size*size-1:0]     w,
    input  logic [data_size*size-1:0]     x,
    input  logic [data_size*size-1:0]     label_in,
    input  logic [index_size-1:0]         w_layer_index,
    input  logic [index_size-1:0]         w_row_index,
    input  logic                          is_update,
    input  logic                          load_w,
    input  logic                          backprop_cost,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [act_type_size-1:0]      act_type_out,
    output logic [dense_type_size-1:0]    dense_type_out,
    output logic [cost_type_size-1:0]     cost_type_out,
    output logic [data_size*size-1:0]     w_out,
    output logic [data_size*size-1:0]     x_out,
    output logic [data_size*size-1:0]     label_out,
    output logic [index_size-1:0]         w_layer_index_out,
    output logic [index_size-1:0]         w_row_index_out,
    output logic                          is_update_out,
    output logic                          load_w_out,
    output logic                          backprop_cost_out,
    output logic [occ_w-1:0]              occupancy,
    output logic [31:0]                   stall_count,
    output logic [31:0]                   xfer_count
);

    localparam int vec_w = data_size * size;
    localparam int pw = act_type_size + dense_type_size + cost_type_size
                      + 3 * vec_w + 2 * index_size + 3;

    logic [pw-1:0]    in_bus;
    logic [pw-1:0]    pay [depth];
    logic [depth-1:0] v;
    logic [depth-1:0] rdy;

    assign in_bus = {act_type, dense_type, cost_type, w, x, label_in,
                     w_layer_index, w_row_index, is_update, load_w, backprop_cost};

    // Stage i can load when it is empty, some later stage is empty, or the tail
    // drains; written as a run of full stages so no signal feeds back on itself.
    always_comb begin
        logic full_run;
        full_run = 1'b1;
        rdy      = '0;
        for (int i = depth - 1; i >= 0; i--) begin
            full_run = full_run & v[i];
            rdy[i]   = out_ready | ~full_run;
        end
    end

    assign in_ready = rdy[0] & ~flush;

    // Valid bits and payload advance stage by stage; flush only clears valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int i = 0; i < depth; i++) begin
                pay[i] <= '0;
            end
        end else if (flush) begin
            v <= '0;
        end else begin
            if (rdy[0]) begin
                v[0] <= in_valid;
                if (in_valid) begin
                    pay[0] <= in_bus;
                end
            end
            for (int i = 1; i < depth; i++) begin
                if (rdy[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        pay[i] <= pay[i-1];
                    end
                end
            end
        end
    end

    assign out_valid = v[depth-1];
    assign {act_type_out, dense_type_out, cost_type_out, w_out, x_out, label_out,
            w_layer_index_out, w_row_index_out, is_update_out, load_w_out,
            backprop_cost_out} = pay[depth-1];

    // Occupancy is the population count of the stage valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < depth; i++) begin
            occupancy = occupancy + occ_w'(v[i]);
        end
    end

`ifdef DECODE_DENSE_PIPE_STATS_EN
    // Saturating tail statistics; flush leaves them untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count <= '0;
            xfer_count  <= '0;
        end else if (out_valid) begin
            if (out_ready) begin
                if (xfer_count != 32'hFFFF_FFFF) begin
                    xfer_count <= xfer_count + 32'd1;
                end
            end else begin
                if (stall_count != 32'hFFFF_FFFF) begin
                    stall_count <= stall_count + 32'd1;
                end
            end
        end
    end
`else
    assign stall_count = '0;
    assign xfer_count  = '0;
`endif

endmodule

// File: tb/tb_decode_dense_pipe.sv
// Bench for decode_dense_pipe: a depth-2 and a depth-3 instance share stimulus
// and are each compared every cycle against a queue-of-positions model.
module tb_decode_dense_pipe;

    localparam int SZ = 3;
    localparam int DW = 16;
    localparam int IW = 32;
    localparam int VW = SZ * DW;
    localparam int PW = 4 + 4 + 8 + 3 * VW + 2 * IW + 3;
    localparam int XO = 3 + 2 * IW + VW;

    typedef struct {
        int            pos;
        logic [PW-1:0] data;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [PW-1:0] stim = '0;

    logic [3:0]    act_type, dense_type;
    logic [7:0]    cost_type;
    logic [VW-1:0] w, x, label_in;
    logic [IW-1:0] w_layer_index, w_row_index;
    logic          is_update, load_w, backprop_cost;

    assign {act_type, dense_type, cost_type, w, x, label_in, w_layer_index,
            w_row_index, is_update, load_w, backprop_cost} = stim;

    logic          in_ready_a, out_valid_a, in_ready_b, out_valid_b;
    logic [3:0]    act_a, dense_a, act_b, dense_b;
    logic [7:0]    cost_a, cost_b;
    logic [VW-1:0] w_a, x_a, lab_a, w_b, x_b, lab_b;
    logic [IW-1:0] li_a, ri_a, li_b, ri_b;
    logic          upd_a, ldw_a, bpc_a, upd_b, ldw_b, bpc_b;
    logic [1:0]    occ_a, occ_b;
    logic [31:0]   stall_a, xfer_a, stall_b, xfer_b;
    logic [PW-1:0] pay_a, pay_b;

    assign pay_a = {act_a, dense_a, cost_a, w_a, x_a, lab_a, li_a, ri_a, upd_a, ldw_a, bpc_a};
    assign pay_b = {act_b, dense_b, cost_b, w_b, x_b, lab_b, li_b, ri_b, upd_b, ldw_b, bpc_b};

    decode_dense_pipe #(.depth(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .act_type(act_type), .dense_type(dense_type), .cost_type(cost_type),
        .w(w), .x(x), .label_in(label_in), .w_layer_index(w_layer_index),
        .w_row_index(w_row_index), .is_update(is_update), .load_w(load_w),
        .backprop_cost(backprop_cost), .out_valid(out_valid_a), .out_ready(out_ready),
        .act_type_out(act_a), .dense_type_out(dense_a), .cost_type_out(cost_a),
        .w_out(w_a), .x_out(x_a), .label_out(lab_a), .w_layer_index_out(li_a),
        .w_row_index_out(ri_a), .is_update_out(upd_a), .load_w_out(ldw_a),
        .backprop_cost_out(bpc_a), .occupancy(occ_a), .stall_count(stall_a),
        .xfer_count(xfer_a)
    );

    decode_dense_pipe #(.depth(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .act_type(act_type), .dense_type(dense_type), .cost_type(cost_type),
        .w(w), .x(x), .label_in(label_in), .w_layer_index(w_layer_index),
        .w_row_index(w_row_index), .is_update(is_update), .load_w(load_w),
        .backprop_cost(backprop_cost), .out_valid(out_valid_b), .out_ready(out_ready),
        .act_type_out(act_b), .dense_type_out(dense_b), .cost_type_out(cost_b),
        .w_out(w_b), .x_out(x_b), .label_out(lab_b), .w_layer_index_out(li_b),
        .w_row_index_out(ri_b), .is_update_out(upd_b), .load_w_out(ldw_b),
        .backprop_cost_out(bpc_b), .occupancy(occ_b), .stall_count(stall_b),
        .xfer_count(xfer_b)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    item_t mq0[$];
    item_t mq1[$];
    logic [31:0] exp_stall [2];
    logic [31:0] exp_xfer [2];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] rand_bundle();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t[PW-1:0];
    endfunction

    // Items are kept oldest first with their stage position; each cycle an item
    // steps forward if the slot ahead is free or being vacated, the tail leaves
    // on out_ready, and a new item enters at position 0 when that slot frees up.
    task automatic model_cycle(input int m, input logic obs_ir, input logic obs_ov,
                               input int obs_occ, input logic [PW-1:0] obs_pay,
                               input logic [31:0] obs_stall, input logic [31:0] obs_xfer);
        item_t q[$];
        item_t nq[$];
        bit    mv[$];
        item_t it;
        int    d;
        bit    ir, ov;
        string s;
        d = (m == 0) ? 2 : 3;
        s = (m == 0) ? "d2" : "d3";
        if (m == 0) q = mq0; else q = mq1;
        for (int k = 0; k < q.size(); k++) begin
            if (k == 0) mv.push_back(q[0].pos == d - 1 ? out_ready : 1'b1);
            else mv.push_back((q[k-1].pos != q[k].pos + 1) || mv[k-1]);
        end
        ir = !flush && (q.size() == 0 || q[q.size()-1].pos != 0 || mv[q.size()-1]);
        ov = q.size() > 0 && q[0].pos == d - 1;
        chk({s, "_in_ready"}, 256'(obs_ir), 256'(ir));
        chk({s, "_out_valid"}, 256'(obs_ov), 256'(ov));
        chk({s, "_occupancy"}, 256'(obs_occ), 256'(q.size()));
        if (ov) chk({s, "_payload"}, 256'(obs_pay), 256'(q[0].data));
        chk({s, "_stall_count"}, 256'(obs_stall), 256'(exp_stall[m]));
        chk({s, "_xfer_count"}, 256'(obs_xfer), 256'(exp_xfer[m]));
`ifdef DECODE_DENSE_PIPE_STATS_EN
        if (ov && out_ready) exp_xfer[m] = exp_xfer[m] + 1;
        if (ov && !out_ready) exp_stall[m] = exp_stall[m] + 1;
`endif
        for (int k = 0; k < q.size(); k++) begin
            it = q[k];
            if (mv[k]) begin
                if (it.pos != d - 1) begin
                    it.pos++;
                    nq.push_back(it);
                end
            end else begin
                nq.push_back(it);
            end
        end
        if (flush) nq = {};
        else if (in_valid && ir) begin
            it.pos = 0;
            it.data = stim;
            nq.push_back(it);
        end
        if (m == 0) mq0 = nq; else mq1 = nq;
    endtask

    task automatic cycle(input bit iv, input bit ordy, input bit fl, input bit force_x);
        @(negedge clk);
        in_valid = iv;
        out_ready = ordy;
        flush = fl;
        stim = rand_bundle();
        if (force_x) stim[XO +: VW] = 48'h0001_0002_0003;
        #1;
        model_cycle(0, in_ready_a, out_valid_a, int'(occ_a), pay_a, stall_a, xfer_a);
        model_cycle(1, in_ready_b, out_valid_b, int'(occ_b), pay_b, stall_b, xfer_b);
    endtask

    task automatic reset_checks();
        chk("rst_out_valid_d2", 256'(out_valid_a), 256'(0));
        chk("rst_out_valid_d3", 256'(out_valid_b), 256'(0));
        chk("rst_payload_d2", 256'(pay_a), 256'(0));
        chk("rst_payload_d3", 256'(pay_b), 256'(0));
        chk("rst_occ_d2", 256'(occ_a), 256'(0));
        chk("rst_occ_d3", 256'(occ_b), 256'(0));
        chk("rst_in_ready_d2", 256'(in_ready_a), 256'(1));
        chk("rst_in_ready_d3", 256'(in_ready_b), 256'(1));
        chk("rst_stall_d3", 256'(stall_b), 256'(0));
        chk("rst_xfer_d3", 256'(xfer_b), 256'(0));
        mq0 = {};
        mq1 = {};
        for (int m = 0; m < 2; m++) begin
            exp_stall[m] = '0;
            exp_xfer[m] = '0;
        end
    endtask

    initial begin
        out_ready = 1'b1;
        #3;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back stream with no backpressure
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
        // fill under backpressure, then hold with a fixed x payload
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        // full pipe draining and accepting in the same cycles
        for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
        // empty, refill two entries, then flush with in_valid high
        cycle(0, 0, 1, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 0);
        // randomised traffic
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 29) == 0, 0);

        // asynchronous reset mid-stream, away from any clock edge
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;

        // stalled tail after reset accumulates stall cycles
        for (int i = 0; i < 14; i++) cycle(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/decode_dense_pipe.md
Name: decode_dense_pipe

Overview:
- Elastic, parametrised-depth pipeline carrying the decode-to-dense control and data bundle: act/dense/cost type, weight row, layer/row index, is_update/load_w/backprop_cost, x, label.
- Replaces the fixed single-cycle, always-advancing delay stage with valid/ready flow control, backpressure, synchronous flush, occupancy reporting and asynchronous reset.
- Sits between the instruction decoder and the dense layer unit.

Parameters:
- size, 3, elements per vector bus (w, x, label)
- data_size, 16, bits per vector element
- act_type_size, 4, width of act_type
- dense_type_size, 4, width of dense_type
- cost_type_size, 8, width of cost_type
- index_size, 32, width of w_layer_index and w_row_index
- depth, 2, number of register stages; legal range is depth >= 1
- occ_w, $clog2(depth+1), occupancy width (derived; not overridden)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous pipeline clear
- in_valid  in  1  upstream bundle valid
- in_ready  out  1  pipe accepts bundle this cycle
- act_type, dense_type, cost_type  in  act/dense/cost_type_size  op codes
- w, x, label_in  in  data_size*size each  vector payloads
- w_layer_index, w_row_index  in  index_size each  weight address
- is_update, load_w, backprop_cost  in  1 each  control flags
- out_valid  out  1  bundle at tail valid
- out_ready  in  1  downstream accepts
- act_type_out, dense_type_out, cost_type_out, w_out, x_out, label_out, w_layer_index_out, w_row_index_out, is_update_out, load_w_out, backprop_cost_out  out  matching widths  tail-stage payload
- occupancy  out  occ_w  number of valid stages
- stall_count, xfer_count  out  32 each  statistics (see Optional Feature)

Behaviour:
- Stage i (0 = head, depth-1 = tail) holds a valid bit v[i] and a full payload copy.
- ready[depth-1] = out_ready; ready[i] = !v[i] || ready[i+1]; in_ready = ready[0] && !flush. This is a combinational path from out_ready back to in_ready; this is accepted.
- Stage i loads when ready[i]: v[0] <= in_valid && in_ready; v[i] <= v[i-1] for i > 0. The payload is copied alongside v.
- A stage whose ready is low holds its payload and valid bit unchanged. Tail outputs stay stable while out_valid && !out_ready.
- out_valid = v[depth-1]; outputs always reflect tail-stage registers.
- Latency: a bundle accepted at edge N appears at the outputs after edge N+depth-1 when there is no backpressure, i.e. depth register stages. Throughput is 1 bundle/cycle sustained.
- Full: all v = 1 and out_ready = 0 gives in_ready = 0, and nothing moves.
- Full and out_ready = 1 in the same cycle: the tail drains and the head accepts simultaneously; occupancy is unchanged.
- Empty: out_valid = 0; a bubble in a middle stage is collapsed by the upstream stage advancing into it.
- occupancy = popcount(v), registered-state derived, range 0..depth.
- Flush:
  - All v cleared on the next edge; in_ready = 0 that cycle, so any in_valid is dropped.
  - A tail transfer in the flush cycle (out_valid && out_ready) still counts as delivered.
  - Payload registers keep stale data; it is don't-care when v = 0.
- Reset (asserted at any time, including mid-transfer):
  - All v = 0; all payload outputs = 0; occupancy = 0.
  - out_valid = 0 immediately (asynchronous); in_ready = out_ready || !v chain, i.e. 1 once flush = 0.
  - Statistics are also cleared.
- Index and vector fields pass through bit-exact; no arithmetic is performed on the payload.

Optional Feature:
- Macro: DECODE_DENSE_PIPE_STATS_EN.
- Defined:
  - stall_count increments each cycle out_valid && !out_ready.
  - xfer_count increments each cycle out_valid && out_ready.
  - Both are 32-bit, saturate at 0xFFFFFFFF, are cleared only by rst_n (not flush), and are registered (visible the cycle after the event).
- Not defined: both ports are tied to 0; no counter logic is synthesised; the port list is unchanged.

Test Plan:
- depth=2, out_ready=1, inject 5 bundles back-to-back (w_row_index 0..4) -> out_valid first high 2 cycles after first accept; indices emerge 0..4 consecutively, no gaps; in_ready never low.
- depth=3, out_ready=0, in_valid=1 continuously -> exactly 3 accepts, then in_ready=0, occupancy=3; raise out_ready -> outputs drain in order, with one accept per drain cycle.
- Full pipe, out_ready=1 and in_valid=1 in the same cycle -> occupancy stays 3; output and input transfer together; no loss or duplication.
- Payload hold: out_valid=1, out_ready=0 for 4 cycles with x_out=0x0001_0002_0003 -> outputs bit-stable all 4 cycles.
- flush with occupancy=2 and in_valid=1 -> next cycle occupancy=0, out_valid=0, and the flush-cycle input is not seen at the output.
- rst_n pulsed low mid-stream -> out_valid drops without a clock edge; all outputs 0; with STATS_EN, stall_count=xfer_count=0; after 10 stalled cycles stall_count=10.
